// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver with an internal baud-tick generator.
// Emits one byte per frame with a single-cycle done pulse; a low stop bit
// produces a single-cycle frame-error pulse and the receiver then waits for
// the line to return high before hunting for the next start bit.
module uart_rx_os16 #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 19_200,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DIVISOR  = (CLK_FREQ + 8 * BAUD) / (16 * BAUD)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done,
    output logic            frame_err,
    output logic            busy
);

    localparam int TW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIVISOR - 1);
    localparam logic [3:0]    MID_START = 4'd7;
    localparam logic [3:0]    BIT_LAST  = 4'd15;
    localparam logic [3:0]    STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    logic            r_rx_p0;
    logic            r_rx_p1;
    logic            w_rx_s;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_tick_cnt;
    logic [TW-1:0]   w_tick_cnt_nxt;
    logic            w_tick;
    logic [3:0]      r_s_cnt;
    logic [3:0]      w_s_cnt_nxt;
    logic [NW-1:0]   r_n_cnt;
    logic [NW-1:0]   w_n_cnt_nxt;
    logic [DBIT-1:0] r_shreg;
    logic [DBIT-1:0] w_shreg_nxt;
    logic [DBIT-1:0] r_data;
    logic [DBIT-1:0] w_data_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_err;
    logic            w_err_nxt;

    assign w_rx_s = r_rx_p1;
    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Two-flop synchroniser for the asynchronous line; idles (and resets) high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_p0 <= 1'b1;
            r_rx_p1 <= 1'b1;
        end else begin
            r_rx_p0 <= rx;
            r_rx_p1 <= r_rx_p0;
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_s_cnt    <= '0;
            r_n_cnt    <= '0;
            r_shreg    <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_s_cnt    <= w_s_cnt_nxt;
            r_n_cnt    <= w_n_cnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_data     <= w_data_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Next-state logic: tick divider, oversample counting and frame decoding.
    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + TW'(1);
        w_s_cnt_nxt    = r_s_cnt;
        w_n_cnt_nxt    = r_n_cnt;
        w_shreg_nxt    = r_shreg;
        w_data_nxt     = r_data;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Divider held at zero while idle; the detection cycle counts
                // as the first divider step so sampling phase tracks the edge.
                w_tick_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt    = S_START;
                    w_s_cnt_nxt    = '0;
                    w_tick_cnt_nxt = TW'(1);
                end
            end

            S_START: begin
                if (w_tick) begin
                    if (r_s_cnt == MID_START) begin
                        w_s_cnt_nxt = '0;
                        if (!w_rx_s) begin
                            w_state_nxt = S_DATA;
                            w_n_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    if (r_s_cnt == BIT_LAST) begin
                        w_s_cnt_nxt = '0;
                        w_shreg_nxt = {w_rx_s, r_shreg[DBIT-1:1]};
                        if (r_n_cnt == N_LAST) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_n_cnt_nxt = r_n_cnt + NW'(1);
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end

            S_STOP: begin
                if (w_tick) begin
                    if (r_s_cnt == STOP_LAST) begin
                        w_s_cnt_nxt = '0;
                        if (w_rx_s) begin
                            w_data_nxt  = r_shreg;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_WAIT_HI;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end

            S_WAIT_HI: begin
                // A held-low line (break) must not re-trigger a frame.
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rx_data   = r_data;
    assign rx_done   = r_done;
    assign frame_err = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at DIVISOR=10 (160 clocks per bit).
module tb_uart_rx_os16;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CLK  = 160;
    // Drive-to-done latency: 2 sync flops + 1 detect edge, then 16*D*9+8*D-1.
    localparam int LAT      = 1522;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    uart_rx_os16 #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DBIT     (8),
        .SB_TICK  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts, logs received bytes, flags illegal pulse shapes.
    int         n_done = 0;
    int         n_err = 0;
    int         n_viol = 0;
    int         last_done_cyc = 0;
    logic [7:0] d_log[$];
    logic       prev_done = 1'b0;
    logic       prev_err = 1'b0;

    always @(negedge clk) begin
        if (rx_done) begin
            n_done++;
            last_done_cyc = cyc;
            d_log.push_back(rx_data);
        end
        if (frame_err) n_err++;
        if (rx_done && frame_err) n_viol++;
        if ((rx_done && prev_done) || (frame_err && prev_err)) n_viol++;
        prev_done = rx_done;
        prev_err  = frame_err;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t_start = 0;

    // Caller is at posedge+1; leaves the line at stop_v afterwards.
    task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_v);
        t_start = cyc;
        rx = 1'b0;
        idle(bclk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bclk);
        end
        rx = stop_v;
        idle(bclk);
    endtask

    int d0;
    int e0;
    int c1;
    logic [7:0] b5a;

    initial begin
        // Reset state
        reset = 1'b0;
        rx    = 1'b1;
        idle(3);
        check("rst_data", int'(rx_data), 0);
        check("rst_done", int'(rx_done), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        idle(20);

        // 1) single good frame, exact latency
        d0 = n_done; e0 = n_err;
        send_frame(8'hA5, BIT_CLK, 1'b1);
        idle(40);
        check("t1_ndone", n_done - d0, 1);
        check("t1_data", int'(rx_data), 'hA5);
        check("t1_latency", last_done_cyc - t_start, LAT);
        check("t1_nferr", n_err - e0, 0);
        check("t1_busy", int'(busy), 0);

        // 2) back-to-back frames, no idle gap
        d0 = n_done;
        send_frame(8'h00, BIT_CLK, 1'b1);
        c1 = last_done_cyc;
        send_frame(8'hFF, BIT_CLK, 1'b1);
        idle(40);
        check("t2_ndone", n_done - d0, 2);
        check("t2_first", int'(d_log[d_log.size()-2]), 'h00);
        check("t2_second", int'(d_log[d_log.size()-1]), 'hFF);
        check("t2_spacing", last_done_cyc - c1, 1600);
        check("t2_data", int'(rx_data), 'hFF);

        // 3) short low glitch is rejected at mid start bit
        d0 = n_done; e0 = n_err;
        rx = 1'b0;
        idle(40);
        check("t3_busy_mid", int'(busy), 1);
        rx = 1'b1;
        idle(300);
        check("t3_ndone", n_done - d0, 0);
        check("t3_nferr", n_err - e0, 0);
        check("t3_busy", int'(busy), 0);
        check("t3_data", int'(rx_data), 'hFF);

        // 4) low stop bit followed by a break, then recovery
        d0 = n_done; e0 = n_err;
        send_frame(8'h3C, BIT_CLK, 1'b0);
        idle(3000);
        check("t4_nferr", n_err - e0, 1);
        check("t4_ndone", n_done - d0, 0);
        check("t4_busy_brk", int'(busy), 1);
        check("t4_data", int'(rx_data), 'hFF);
        rx = 1'b1;
        idle(20);
        check("t4_busy_rel", int'(busy), 0);
        check("t4_nferr_rel", n_err - e0, 1);
        send_frame(8'h81, BIT_CLK, 1'b1);
        idle(40);
        check("t4_ndone_81", n_done - d0, 1);
        check("t4_data_81", int'(rx_data), 'h81);

        // 5) reset in the middle of data bit 4
        d0 = n_done; e0 = n_err;
        b5a = 8'h5A;
        rx = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = b5a[i];
            idle(BIT_CLK);
        end
        rx = b5a[4];
        idle(BIT_CLK / 2);
        reset = 1'b0;
        idle(2);
        check("t5_busy_rst", int'(busy), 0);
        reset = 1'b1;
        rx = 1'b1;
        idle(2000);
        check("t5_ndone", n_done - d0, 0);
        check("t5_nferr", n_err - e0, 0);
        check("t5_data", int'(rx_data), 0);
        check("t5_busy", int'(busy), 0);
        send_frame(8'h5A, BIT_CLK, 1'b1);
        idle(40);
        check("t5_ndone_5a", n_done - d0, 1);
        check("t5_data_5a", int'(rx_data), 'h5A);

        // 6) +/-3% baud skew
        d0 = n_done; e0 = n_err;
        send_frame(8'h96, 155, 1'b1);
        idle(40);
        check("t6_fast_data", int'(rx_data), 'h96);
        check("t6_fast_ndone", n_done - d0, 1);
        send_frame(8'h96, 165, 1'b1);
        idle(40);
        check("t6_slow_data", int'(rx_data), 'h96);
        check("t6_slow_ndone", n_done - d0, 2);
        check("t6_nferr", n_err - e0, 0);

        check("pulse_rules", n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
